// File: rtl/fdivsqrt_sched_if.sv
// Handshake bundle between FPU/IEU issue logic and the divide/sqrt sequencer.
// The issue side drives requests (master); the sequencer returns grants and datapath control (slave).
interface fdivsqrt_sched_if #(
    parameter int XLEN = 64
);
    localparam int CLOG = $clog2(XLEN + 2);

    logic            FpReqE;
    logic            FpSqrtE;
    logic [1:0]      FmtE;
    logic            FpSpecialE;
    logic            IntReqE;
    logic [CLOG-1:0] IntDigitsE;
    logic            StallM;
    logic            FlushE;

    logic            FpGntE;
    logic            IntGntE;
    logic            IFDivStartE;
    logic            FDivBusyE;
    logic            SqrtE;
    logic            IntOwnerE;
    logic            FDivDoneE;

    modport master (
        output FpReqE, FpSqrtE, FmtE, FpSpecialE, IntReqE, IntDigitsE, StallM, FlushE,
        input  FpGntE, IntGntE, IFDivStartE, FDivBusyE, SqrtE, IntOwnerE, FDivDoneE
    );

    modport slave (
        input  FpReqE, FpSqrtE, FmtE, FpSpecialE, IntReqE, IntDigitsE, StallM, FlushE,
        output FpGntE, IntGntE, IFDivStartE, FDivBusyE, SqrtE, IntOwnerE, FDivDoneE
    );
endinterface

// File: rtl/fdivsqrt_sched.sv
// Round-robin sequencer for the shared radix-R divide/sqrt iteration datapath.
// Optional FDIVSQRT_SPECIAL_BYPASS_EN sends FP special-operand requests straight to DONE.
module fdivsqrt_sched #(
    parameter int RADIX     = 4,
    parameter int DIVCOPIES = 2,
    parameter int XLEN      = 64,
    parameter int CNTW      = 6
) (
    input  logic              clk,
    input  logic              resetn,
    fdivsqrt_sched_if.slave   bus
);
    localparam int LOGR  = $clog2(RADIX);
    localparam int B     = LOGR * DIVCOPIES;
    localparam int CLOG  = $clog2(XLEN + 2);
    // FP cycle counts: significand bits plus 3 guard/integer bits, ceil-divided by bits per cycle
    localparam int CYC_S = (23 + 3 + B - 1) / B;
    localparam int CYC_D = (52 + 3 + B - 1) / B;
    localparam int CYC_H = (10 + 3 + B - 1) / B;
    localparam int CYC_Q = (112 + 3 + B - 1) / B;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    function automatic logic [CNTW-1:0] fp_cnt_init(input logic [1:0] fmt);
        logic [CNTW-1:0] v;
        case (fmt)
            2'b00:   v = CNTW'(CYC_S - 1);
            2'b01:   v = CNTW'(CYC_D - 1);
            2'b10:   v = CNTW'(CYC_H - 1);
            default: v = CNTW'(CYC_Q - 1);
        endcase
        return v;
    endfunction

    state_t          r_state;
    logic [CNTW-1:0] r_cnt;
    logic            r_rr_int;
    logic            r_sqrt;
    logic            r_owner;

    state_t          w_state_nxt;
    logic [CNTW-1:0] w_cnt_nxt;
    logic            w_rr_nxt;
    logic            w_sqrt_nxt;
    logic            w_owner_nxt;
    logic            w_fp_gnt;
    logic            w_int_gnt;
    logic            w_done;
    logic            w_pick_int;
    logic [CLOG:0]   w_int_cyc;
    logic [CNTW-1:0] w_int_init;

`ifndef FDIVSQRT_SPECIAL_BYPASS_EN
    logic w_unused_special;
    assign w_unused_special = bus.FpSpecialE;
`endif

    // Integer iterations: ceil(IntDigitsE / B), with a zero digit count still taking one cycle
    assign w_int_cyc  = ({1'b0, bus.IntDigitsE} + (CLOG+1)'(B - 1)) / (CLOG+1)'(B);
    assign w_int_init = (w_int_cyc == '0) ? '0 : CNTW'(w_int_cyc - (CLOG+1)'(1));
    assign w_pick_int = bus.IntReqE & (~bus.FpReqE | r_rr_int);

    // Next-state, grant and counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rr_nxt    = r_rr_int;
        w_sqrt_nxt  = r_sqrt;
        w_owner_nxt = r_owner;
        w_fp_gnt    = 1'b0;
        w_int_gnt   = 1'b0;
        w_done      = 1'b0;
        if (bus.FlushE) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (resetn & (bus.FpReqE | bus.IntReqE)) begin
                        if (w_pick_int) begin
                            w_int_gnt   = 1'b1;
                            w_sqrt_nxt  = 1'b0;
                            w_owner_nxt = 1'b1;
                            w_cnt_nxt   = w_int_init;
                            w_rr_nxt    = 1'b0;
                            w_state_nxt = S_BUSY;
                        end else begin
                            w_fp_gnt    = 1'b1;
                            w_sqrt_nxt  = bus.FpSqrtE;
                            w_owner_nxt = 1'b0;
                            w_cnt_nxt   = fp_cnt_init(bus.FmtE);
                            w_rr_nxt    = 1'b1;
`ifdef FDIVSQRT_SPECIAL_BYPASS_EN
                            if (bus.FpSpecialE) begin
                                w_state_nxt = S_DONE;
                                w_cnt_nxt   = '0;
                            end else begin
                                w_state_nxt = S_BUSY;
                            end
`else
                            w_state_nxt = S_BUSY;
`endif
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt - CNTW'(1);
                    end
                end
                S_DONE: begin
                    w_done = 1'b1;
                    if (bus.StallM) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, counter, arbitration pointer and per-op flags
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rr_int <= 1'b0;
            r_sqrt   <= 1'b0;
            r_owner  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rr_int <= w_rr_nxt;
            r_sqrt   <= w_sqrt_nxt;
            r_owner  <= w_owner_nxt;
        end
    end

    // Start pulse feeds the datapath enable so init values are captured at the grant edge
    assign bus.FpGntE      = w_fp_gnt;
    assign bus.IntGntE     = w_int_gnt;
    assign bus.IFDivStartE = w_fp_gnt | w_int_gnt;
    assign bus.FDivBusyE   = w_fp_gnt | w_int_gnt | (r_state == S_BUSY);
    assign bus.SqrtE       = r_sqrt;
    assign bus.IntOwnerE   = r_owner;
    assign bus.FDivDoneE   = w_done;
endmodule
